// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory definitions for the loader, instruction memory and fetch stage.
// Loader state encoding is fixed so that debug taps and the fetch side agree on it.
package imem_loader_pkg;

    // Instruction-memory geometry shared with imem and fetch
    localparam int unsigned IMEM_ADDR_W = 7;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned BYTE_W      = 8;

    // MIPS NOP (sll $0,$0,0); also the idle value of the write-data bus
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Loader FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } loaderState_t;

    // One instruction-memory write beat as seen by the memory
    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [INSTR_W-1:0]     data;
    } imemWrite_t;

    // Word address of the n-th loaded word, wrapping at the memory size
    function automatic logic [IMEM_ADDR_W-1:0] wordAddr(input int unsigned base,
                                                        input logic [IMEM_ADDR_W:0] idx);
        return IMEM_ADDR_W'(base) + IMEM_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader control, byte-stream and instruction-memory write signals bundled as one port.
// master: the side feeding bytes and watching status; slave: the loader itself.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
);

    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic              chk_err;

    modport master (
        output start, load_len, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, chk_err
    );

    modport slave (
        input  start, load_len, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold, chk_err
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes big-endian into DATA_W-bit words (first byte lands in the MSBs)
// and emits a registered one-cycle wordValid with the completed word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              byteFire,
    input  logic [7:0]        byteIn,
    output logic              lastByte_c,
    output logic              wordValid,
    output logic [DATA_W-1:0] wordData
);

    localparam int unsigned BYTES = DATA_W / BYTE_W;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned SHR_W = DATA_W - BYTE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] byteCnt;
    logic [SHR_W-1:0] shiftReg;

    // Current byte completes a word
    assign lastByte_c = byteFire && (byteCnt == LAST_CNT);

    // Byte counter, partial-word shift register and completed-word register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byteCnt   <= '0;
            shiftReg  <= '0;
            wordValid <= 1'b0;
            wordData  <= DATA_W'(MIPS_NOP);
        end else begin
            wordValid <= lastByte_c;
            if (byteFire) begin
                byteCnt <= (byteCnt == LAST_CNT) ? '0 : byteCnt + CNT_W'(1);
                if (lastByte_c) begin
                    wordData <= {shiftReg, byteIn};
                end else begin
                    shiftReg <= SHR_W'({shiftReg, byteIn});
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream, writes big-endian words starting at
// BASE_ADDR and holds the CPU until the image is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned DATA_W    = INSTR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           CLK,
    input  logic           RST,
    imem_loader_if.slave   bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    loaderState_t      state;
    logic [LEN_W-1:0]  wordIdx;
    logic [LEN_W-1:0]  loadLen;
    logic [ADDR_W-1:0] wrAddr;
    logic              byteReady;
    logic              busy;
    logic              done;
    logic              cpuHold;

    logic              byteFire;
    logic              packFire;
    logic              lastByte_c;
    logic              lastWord_c;
    logic              wordValid;
    logic [DATA_W-1:0] wordData;

    assign byteFire   = bus.byte_valid && byteReady;
    assign packFire   = byteFire && (state == LOAD);
    assign lastWord_c = (wordIdx + LEN_W'(1)) == loadLen;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xorAcc;
    logic       chkErr;
    logic       chkMatch_c;

    assign chkMatch_c = (xorAcc == bus.byte_data);
`endif

    imem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .byteFire   (packFire),
        .byteIn     (bus.byte_data),
        .lastByte_c (lastByte_c),
        .wordValid  (wordValid),
        .wordData   (wordData)
    );

    // Loader FSM: addressing, word count, status flags and checksum
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wordIdx   <= '0;
            loadLen   <= '0;
            wrAddr    <= ADDR_W'(BASE_ADDR);
            byteReady <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpuHold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xorAcc    <= '0;
            chkErr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        wordIdx <= '0;
                        loadLen <= bus.load_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xorAcc  <= '0;
                        chkErr  <= 1'b0;
`endif
                        if (bus.load_len != '0) begin
                            state     <= LOAD;
                            byteReady <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            cpuHold   <= 1'b1;
                        end else begin
                            // Empty image: straight to DONE, nothing written
                            state     <= DONE;
                            byteReady <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpuHold   <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    if (packFire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xorAcc <= xorAcc ^ bus.byte_data;
`endif
                        if (lastByte_c) begin
                            // Address registers alongside the word the packer completes
                            wrAddr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(wordIdx);
                            wordIdx <= wordIdx + LEN_W'(1);
                            if (lastWord_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= CHK;
`else
                                state     <= DONE;
                                byteReady <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cpuHold   <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (byteFire) begin
                        // A bad image still finishes, but the CPU stays held
                        state     <= DONE;
                        byteReady <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        chkErr    <= !chkMatch_c;
                        cpuHold   <= !chkMatch_c;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready = byteReady;
    assign bus.wr_en      = wordValid;
    assign bus.wr_addr    = wrAddr;
    assign bus.wr_data    = wordData;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.cpu_hold   = cpuHold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.chk_err    = chkErr;
`else
    assign bus.chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 126) share one stimulus
// stream; a table of load vectors plus hand-written reset, zero-length and start-in-LOAD cases.
// Checksum cases are compiled when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [7:0] loadLen;
    logic       bv;
    logic [7:0] bd;

    int tests = 0;
    int fails = 0;
    int readyBad = 0;
    int pulseBad = 0;
    int run0 = 0;
    int run1 = 0;

    logic [38:0] q0[$];
    logic [38:0] q1[$];

    typedef struct packed {
        logic [7:0]  len;
        logic [95:0] bytes;
        logic        gaps;
        logic [95:0] words;
        logic [20:0] addr0;
        logic [20:0] addr1;
    } vec_t;

    vec_t vecs[4];

    always #5 CLK = ~CLK;

    imem_loader_if #(.ADDR_W(7), .DATA_W(32)) bus0 ();
    imem_loader_if #(.ADDR_W(7), .DATA_W(32)) bus1 ();

    assign bus0.start      = start;
    assign bus0.load_len   = loadLen;
    assign bus0.byte_valid = bv;
    assign bus0.byte_data  = bd;
    assign bus1.start      = start;
    assign bus1.load_len   = loadLen;
    assign bus1.byte_valid = bv;
    assign bus1.byte_data  = bd;

    imem_loader #(.ADDR_W(7), .DATA_W(32), .BASE_ADDR(0)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    imem_loader #(.ADDR_W(7), .DATA_W(32), .BASE_ADDR(126)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    // Write logger: records every write beat and flags wr_en held longer than one cycle
    always @(negedge CLK) begin
        if (bus0.wr_en) begin
            q0.push_back({bus0.wr_addr, bus0.wr_data});
            run0 = run0 + 1;
            if (run0 > 1) pulseBad = pulseBad + 1;
        end else begin
            run0 = 0;
        end
        if (bus1.wr_en) begin
            q1.push_back({bus1.wr_addr, bus1.wr_data});
            run1 = run1 + 1;
            if (run1 > 1) pulseBad = pulseBad + 1;
        end else begin
            run1 = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulseStart(input logic [7:0] len);
        start   = 1'b1;
        loadLen = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1 && n < 4) begin
                bv = 1'b0;
                @(negedge CLK);
                if (!bus0.byte_ready) readyBad++;
                tick();
                n++;
            end
        end
        bv = 1'b1;
        bd = b;
        @(negedge CLK);
        if (!bus0.byte_ready) readyBad++;
        tick();
        bv = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!bus0.done && n < 20) begin
            tick();
            n++;
        end
        check({name, " done reached"}, 64'(bus0.done), 64'd1);
        tick();
    endtask

    task automatic checkReset(input string name);
        check({name, " wr_en0"},      64'(bus0.wr_en),      64'd0);
        check({name, " wr_addr0"},    64'(bus0.wr_addr),    64'd0);
        check({name, " wr_addr1"},    64'(bus1.wr_addr),    64'd126);
        check({name, " wr_data0"},    64'(bus0.wr_data),    64'd0);
        check({name, " byte_ready"},  64'(bus0.byte_ready), 64'd0);
        check({name, " busy"},        64'(bus0.busy),       64'd0);
        check({name, " done"},        64'(bus0.done),       64'd0);
        check({name, " cpu_hold"},    64'(bus0.cpu_hold),   64'd1);
        check({name, " chk_err"},     64'(bus0.chk_err),    64'd0);
    endtask

    task automatic runVec(input int idx);
        vec_t v = vecs[idx];
        int nb = 4 * int'(v.len);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
`endif
        q0.delete();
        q1.delete();
        readyBad = 0;
        pulseStart(v.len);
        check($sformatf("v%0d busy after start", idx),     64'(bus0.busy),       64'd1);
        check($sformatf("v%0d byte_ready in LOAD", idx),   64'(bus0.byte_ready), 64'd1);
        check($sformatf("v%0d cpu_hold in LOAD", idx),     64'(bus0.cpu_hold),   64'd1);
        check($sformatf("v%0d done in LOAD", idx),         64'(bus0.done),       64'd0);
        for (int i = 0; i < nb; i++) begin
            sendByte(v.bytes[95-8*i -: 8], v.gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = x ^ v.bytes[95-8*i -: 8];
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(x, v.gaps);
`endif
        waitDone($sformatf("v%0d", idx));
        check($sformatf("v%0d write count0", idx), 64'(q0.size()), 64'(v.len));
        check($sformatf("v%0d write count1", idx), 64'(q1.size()), 64'(v.len));
        for (int k = 0; k < int'(v.len); k++) begin
            if (k < q0.size()) begin
                check($sformatf("v%0d w%0d data0", idx, k), 64'(q0[k][31:0]),  64'(v.words[95-32*k -: 32]));
                check($sformatf("v%0d w%0d addr0", idx, k), 64'(q0[k][38:32]), 64'(v.addr0[20-7*k -: 7]));
            end
            if (k < q1.size()) begin
                check($sformatf("v%0d w%0d data1", idx, k), 64'(q1[k][31:0]),  64'(v.words[95-32*k -: 32]));
                check($sformatf("v%0d w%0d addr1", idx, k), 64'(q1[k][38:32]), 64'(v.addr1[20-7*k -: 7]));
            end
        end
        check($sformatf("v%0d cpu_hold released", idx), 64'(bus0.cpu_hold),   64'd0);
        check($sformatf("v%0d busy cleared", idx),      64'(bus0.busy),       64'd0);
        check($sformatf("v%0d byte_ready cleared", idx),64'(bus0.byte_ready), 64'd0);
        check($sformatf("v%0d chk_err", idx),           64'(bus0.chk_err),    64'd0);
        check($sformatf("v%0d byte_ready held", idx),   64'(readyBad),        64'd0);
    endtask

    initial begin
        logic [7:0] seq[8];
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        seq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};

        vecs[0] = '{len: 8'd2, bytes: 96'h20080005_3C011234_00000000, gaps: 1'b0,
                    words: 96'h20080005_3C011234_00000000,
                    addr0: {7'd0, 7'd1, 7'd0}, addr1: {7'd126, 7'd127, 7'd0}};
        vecs[1] = '{len: 8'd2, bytes: 96'h20080005_3C011234_00000000, gaps: 1'b1,
                    words: 96'h20080005_3C011234_00000000,
                    addr0: {7'd0, 7'd1, 7'd0}, addr1: {7'd126, 7'd127, 7'd0}};
        vecs[2] = '{len: 8'd3, bytes: 96'h20080005_3C011234_AABBCCDD, gaps: 1'b0,
                    words: 96'h20080005_3C011234_AABBCCDD,
                    addr0: {7'd0, 7'd1, 7'd2}, addr1: {7'd126, 7'd127, 7'd0}};
        vecs[3] = '{len: 8'd1, bytes: 96'hDEADBEEF_00000000_00000000, gaps: 1'b1,
                    words: 96'hDEADBEEF_00000000_00000000,
                    addr0: {7'd0, 7'd0, 7'd0}, addr1: {7'd126, 7'd0, 7'd0}};

        RST = 1'b1; start = 1'b0; loadLen = 8'd0; bv = 1'b0; bd = 8'h00;
        repeat (3) tick();
        checkReset("reset");
        RST = 1'b0;
        tick();

        // Zero-length load from IDLE, then again from DONE
        q0.delete(); q1.delete();
        pulseStart(8'd0);
        check("len0 done",       64'(bus0.done),       64'd1);
        check("len0 busy",       64'(bus0.busy),       64'd0);
        check("len0 cpu_hold",   64'(bus0.cpu_hold),   64'd0);
        check("len0 byte_ready", 64'(bus0.byte_ready), 64'd0);
        pulseStart(8'd0);
        repeat (2) tick();
        check("len0 again done", 64'(bus0.done),       64'd1);
        check("len0 no writes",  64'(q0.size()),       64'd0);

        // Table-driven loads
        for (int i = 0; i < 4; i++) runVec(i);

        // start during LOAD must not change the length
        q0.delete(); q1.delete();
        pulseStart(8'd2);
        sendByte(seq[0], 1'b0);
        sendByte(seq[1], 1'b0);
        pulseStart(8'd1);
        sendByte(seq[2], 1'b0);
        sendByte(seq[3], 1'b0);
        check("ignored start done", 64'(bus0.done), 64'd0);
        check("ignored start busy", 64'(bus0.busy), 64'd1);
        for (int i = 4; i < 8; i++) sendByte(seq[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ seq[i];
        sendByte(x, 1'b0);
`endif
        waitDone("ignored start");
        check("ignored start writes", 64'(q0.size()), 64'd2);
        if (q0.size() == 2) check("ignored start word1", 64'(q0[1]), 64'({7'd1, 32'h3C011234}));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good and bad checksum
        pulseStart(8'd1);
        for (int i = 1; i <= 4; i++) sendByte(8'(i), 1'b0);
        sendByte(8'h04, 1'b0);
        waitDone("chk good");
        check("chk good chk_err",  64'(bus0.chk_err),  64'd0);
        check("chk good cpu_hold", 64'(bus0.cpu_hold), 64'd0);
        pulseStart(8'd1);
        for (int i = 1; i <= 4; i++) sendByte(8'(i), 1'b0);
        sendByte(8'h05, 1'b0);
        waitDone("chk bad");
        check("chk bad chk_err",   64'(bus0.chk_err),  64'd1);
        check("chk bad cpu_hold",  64'(bus0.cpu_hold), 64'd1);
        pulseStart(8'd0);
        check("chk cleared on start", 64'(bus0.chk_err), 64'd0);
`endif

        // Reset mid-word: partial word discarded, no write, then a clean reload
        q0.delete(); q1.delete();
        pulseStart(8'd1);
        sendByte(8'hDE, 1'b0);
        sendByte(8'hAD, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        checkReset("mid-load reset");
        tick();
        RST = 1'b0;
        repeat (6) tick();
        check("mid-load reset writes0", 64'(q0.size()),     64'd0);
        check("mid-load reset writes1", 64'(q1.size()),     64'd0);
        check("mid-load reset hold",    64'(bus0.cpu_hold), 64'd1);
        runVec(2);

        check("wr_en single-cycle", 64'(pulseBad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the fetch-stage read port on instruction memory.
- Accepts a byte stream (e.g. from a UART receiver), assembles big-endian 32-bit MIPS words and issues single-cycle writes into instruction memory.
- Holds the CPU, via cpu_hold, until a complete program image has been written.

Parameters:
- ADDR_W, 7, instruction-memory word-address width (128 words).
- DATA_W, 32, instruction word width; must be a multiple of 8.
- BASE_ADDR, 0, word address of the first written instruction.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE.
- load_len  input  ADDR_W+1  number of words to load; sampled on start; range 0..2^ADDR_W.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader can accept a byte.
- wr_en  output  1  instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  DATA_W  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  level; image complete.
- cpu_hold  output  1  keeps fetch/PC frozen.
- chk_err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Reset values (async on RST=1): state IDLE, all counters 0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, byte_ready=0, busy=0, done=0, chk_err=0, cpu_hold=1.
- States and transitions:
  - IDLE → LOAD on start with load_len>0.
  - IDLE → DONE on start with load_len==0; no writes occur.
  - LOAD → DONE after the last byte of word load_len-1 is accepted. With the optional feature, LOAD → CHK instead.
  - CHK → DONE after the checksum byte is accepted.
  - DONE → LOAD on start with load_len>0. start with load_len==0 in DONE leaves the block in DONE; done stays 1.
  - start in LOAD or CHK is ignored.
- Handshake:
  - byte_ready=1 exactly in LOAD and CHK.
  - A byte is transferred on a rising edge with byte_valid & byte_ready.
  - byte_valid may drop at any time; the assembly state is retained across gaps.
- Word assembly:
  - Big-endian: byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - Byte counter is 2 bits and wraps 3→0.
- Write timing:
  - The edge that accepts byte 3 registers wr_en=1, wr_data and wr_addr; they are visible for exactly one cycle after that edge.
  - wr_en returns to 0 on the next edge unless another word completes, which needs at least 4 cycles.
- Addressing:
  - wr_addr = BASE_ADDR + word_index, computed modulo 2^ADDR_W.
  - Wrap-around is allowed (BASE_ADDR=120, load_len=10 writes 120..127, then 0, 1).
  - load_len=2^ADDR_W writes every location once.
- Status outputs:
  - busy=1 in LOAD and CHK.
  - done=1 in DONE only.
  - cpu_hold=1 in every state except DONE, so the CPU restarts from PC 0 after each reload.
- RST asserted mid-load:
  - Aborts immediately; a partial word is discarded and no write is issued.
  - Words already written remain in memory.
  - cpu_hold=1 until a new load completes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte, the block enters CHK and accepts one more byte.
  - The running XOR of all data bytes must equal that byte.
  - On mismatch, chk_err=1 and it holds until the next start or RST.
  - DONE is entered regardless; cpu_hold is still released only if chk_err=0, otherwise it stays 1.
- When undefined:
  - No CHK state; chk_err is tied to 0.

Decomposition:
- Shared package (imem_pkg):
  - IMEM_ADDR_W=7 and INSTR_W=32, also used by the instruction memory and fetch.
  - Loader state encoding: IDLE=0, LOAD=1, CHK=2, DONE=3.
  - MIPS NOP constant (32'h00000000).
- One natural sub-module, byte_packer: 2-bit byte counter, shift/assemble register and word_valid pulse. The loader FSM owns addressing, status outputs and the checksum.

Test Plan:
- Reset then start, load_len=2, bytes 20 08 00 05 3C 01 12 34 with no gaps → writes 0x20080005@0 then 0x3C011234@1; each wr_en exactly 1 cycle; done=1 and cpu_hold=0 after the second write.
- Same load with byte_valid toggled randomly 50% → identical writes; byte_ready stays 1 throughout LOAD.
- BASE_ADDR=126, load_len=3 → writes at 126, 127, 0; no write at 1.
- start, load_len=1, send 2 bytes, assert RST for 1 cycle → no write; outputs at reset values; restart loads correctly.
- start with load_len=0 → DONE on the next cycle, zero writes; start during LOAD → ignored, length unchanged.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01 02 03 04 then checksum 04 → chk_err=0, cpu_hold=0. Same bytes with checksum 05 → chk_err=1, cpu_hold=1.
